// File: rtl/qcv_if_stage.sv
// qcv instruction fetch stage: request generation, in-order response tracking with
// flush discard, a small prefetch FIFO and the IF/ID pipeline register.
module qcv_if_stage #(
   parameter logic [31:0] BOOT_ADDR   = 32'h0000_0080,
   parameter logic [31:0] DM_EXC_ADDR = 32'h0000_0800,
   parameter int          FIFO_DEPTH  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic        pc_set_i,
   input  logic [1:0]  pc_mux_i,
   input  logic        exc_pc_mux_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] csr_mtvec_i,
   input  logic        id_in_ready_i,
   input  logic        instr_valid_clear_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        instr_valid_id_o,
   output logic [31:0] instr_rdata_id_o,
   output logic        instr_fetch_err_o,
   output logic [31:0] pc_id_o,
   output logic [31:0] pc_if_o
);

   localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int                PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   logic [31:0]      r_fetch_addr;
   logic [31:0]      r_rsp_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_discard;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic             r_halt;
   logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
   logic [31:0]      r_fifo_rdata [FIFO_DEPTH];
   logic             r_fifo_err   [FIFO_DEPTH];
   logic             r_id_valid;
   logic [31:0]      r_id_rdata;
   logic [31:0]      r_id_pc;
   logic             r_id_err;

   logic        w_room;
   logic        w_req;
   logic        w_gnt;
   logic        w_rsp;
   logic        w_keep;
   logic        w_load;
   logic        w_pop;
   logic        w_bypass;
   logic        w_push;
   logic [31:0] w_target;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      w_target = BOOT_ADDR;
      case (pc_mux_i)
         2'b01:   w_target = branch_target_i;
         2'b10:   w_target = exc_pc_mux_i ? DM_EXC_ADDR : csr_mtvec_i;
         default: w_target = BOOT_ADDR;
      endcase
      w_target = w_target & 32'hFFFF_FFFC;
   end

   // Space is reserved for every in-flight request, so a kept response always fits.
   assign w_room   = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
   assign w_req    = instr_req_i & ~pc_set_i & ~r_halt & w_room & ~rst_i;
   assign w_gnt    = w_req & instr_gnt_i;
   assign w_rsp    = instr_rvalid_i & (r_outstanding != '0);
   assign w_keep   = w_rsp & ~pc_set_i & (r_discard == '0) & ~r_halt;
   assign w_load   = ~r_id_valid | id_in_ready_i;
   assign w_pop    = w_load & ~instr_valid_clear_i & ~pc_set_i & (r_count != '0);
   assign w_bypass = w_load & ~instr_valid_clear_i & (r_count == '0) & w_keep;
   assign w_push   = w_keep & ~w_bypass;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_addr  <= BOOT_ADDR;
         r_rsp_pc      <= BOOT_ADDR;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_halt        <= 1'b0;
      end else begin
         r_outstanding <= r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rsp);
         if (pc_set_i) begin
            r_fetch_addr <= w_target;
            r_rsp_pc     <= w_target;
            r_discard    <= r_outstanding - CNT_W'(w_rsp);
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_halt       <= 1'b0;
         end else begin
            if (w_gnt)
               r_fetch_addr <= r_fetch_addr + 32'd4;
            if (w_keep)
               r_rsp_pc <= r_rsp_pc + 32'd4;
            if (w_rsp && (r_discard != '0))
               r_discard <= r_discard - CNT_W'(1);
            if (w_keep && instr_err_i)
               r_halt <= 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push)
               r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
               r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
         r_fifo_rdata[r_wr_ptr] <= instr_rdata_i;
         r_fifo_err[r_wr_ptr]   <= instr_err_i;
      end
   end

   // IF/ID register: redirect and kill both win over a load.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_id_valid <= 1'b0;
         r_id_rdata <= '0;
         r_id_pc    <= '0;
         r_id_err   <= 1'b0;
      end else if (pc_set_i || instr_valid_clear_i) begin
         r_id_valid <= 1'b0;
      end else if (w_load) begin
         if (w_pop) begin
            r_id_valid <= 1'b1;
            r_id_rdata <= r_fifo_rdata[r_rd_ptr];
            r_id_pc    <= r_fifo_pc[r_rd_ptr];
            r_id_err   <= r_fifo_err[r_rd_ptr];
         end else if (w_bypass) begin
            r_id_valid <= 1'b1;
            r_id_rdata <= instr_rdata_i;
            r_id_pc    <= r_rsp_pc;
            r_id_err   <= instr_err_i;
         end else begin
            r_id_valid <= 1'b0;
         end
      end
   end

   assign instr_req_o       = w_req;
   assign instr_addr_o      = r_fetch_addr;
   assign pc_if_o           = r_fetch_addr;
   assign instr_valid_id_o  = r_id_valid;
   assign instr_rdata_id_o  = r_id_rdata;
   assign instr_fetch_err_o = r_id_err;
   assign pc_id_o           = r_id_pc;

endmodule

// File: tb/tb_qcv_if_stage.sv
// Directed bench for qcv_if_stage: a one-cycle in-order memory model plus a redirect
// vector table and hand-written sequences for stalls, flushes, fetch errors and kills.
module tb_qcv_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req_i = 1'b0;
   logic        pc_set_i = 1'b0;
   logic [1:0]  pc_mux_i = 2'b00;
   logic        exc_pc_mux_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic [31:0] csr_mtvec_i = '0;
   logic        id_in_ready_i = 1'b0;
   logic        instr_valid_clear_i = 1'b0;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_err_i = 1'b0;
   logic        instr_valid_id_o;
   logic [31:0] instr_rdata_id_o;
   logic        instr_fetch_err_o;
   logic [31:0] pc_id_o;
   logic [31:0] pc_if_o;

   int          n_cmp = 0;
   int          n_err = 0;
   logic        mem_hold = 1'b0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] mq[$];

   typedef struct {
      logic [1:0]  mux;
      logic        exc;
      logic [31:0] br;
      logic [31:0] mtvec;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[6];

   qcv_if_stage dut (
      .clk_i(clk), .rst_i(rst), .instr_req_i(instr_req_i), .pc_set_i(pc_set_i),
      .pc_mux_i(pc_mux_i), .exc_pc_mux_i(exc_pc_mux_i), .branch_target_i(branch_target_i),
      .csr_mtvec_i(csr_mtvec_i), .id_in_ready_i(id_in_ready_i),
      .instr_valid_clear_i(instr_valid_clear_i), .instr_req_o(instr_req_o),
      .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
      .instr_valid_id_o(instr_valid_id_o), .instr_rdata_id_o(instr_rdata_id_o),
      .instr_fetch_err_o(instr_fetch_err_o), .pc_id_o(pc_id_o), .pc_if_o(pc_if_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock cycle; the memory answers each granted request in the following cycle.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      logic [31:0] ra;
      #1;
      acc = instr_req_o & instr_gnt_i;
      a   = instr_addr_o;
      @(posedge clk);
      #1;
      if (rst) mq.delete();
      else if (acc) mq.push_back(a);
      if (!mem_hold && !rst && mq.size() > 0) begin
         ra = mq.pop_front();
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = mem_data(ra);
         instr_err_i    = (ra == err_addr);
      end else begin
         instr_rvalid_i = 1'b0;
         instr_rdata_i  = '0;
         instr_err_i    = 1'b0;
      end
      #1;
   endtask

   // Holds pc_set for one cycle; returns in the first cycle after the redirect.
   task automatic redirect(input logic [1:0] m, input logic e, input logic [31:0] br,
                           input logic [31:0] mt);
      pc_set_i = 1'b1; pc_mux_i = m; exc_pc_mux_i = e;
      branch_target_i = br; csr_mtvec_i = mt;
      tick();
      pc_set_i = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{mux: 2'b00, exc: 1'b0, br: 32'h0000_0400, mtvec: 32'h0, exp: 32'h0000_0080};
      vecs[1] = '{mux: 2'b01, exc: 1'b0, br: 32'h0000_0200, mtvec: 32'h0, exp: 32'h0000_0200};
      vecs[2] = '{mux: 2'b01, exc: 1'b1, br: 32'h0000_0203, mtvec: 32'h0, exp: 32'h0000_0200};
      vecs[3] = '{mux: 2'b10, exc: 1'b0, br: 32'h0, mtvec: 32'h0000_1003, exp: 32'h0000_1000};
      vecs[4] = '{mux: 2'b10, exc: 1'b1, br: 32'h0, mtvec: 32'h0000_1003, exp: 32'h0000_0800};
      vecs[5] = '{mux: 2'b11, exc: 1'b0, br: 32'h0000_0600, mtvec: 32'h0, exp: 32'h0000_0080};

      // Reset values with the controller already requesting.
      instr_req_i = 1'b1; instr_gnt_i = 1'b1; id_in_ready_i = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_req", 32'(instr_req_o), 32'd0);
      chk("rst_addr", instr_addr_o, 32'h80);
      chk("rst_pc_if", pc_if_o, 32'h80);
      chk("rst_valid", 32'(instr_valid_id_o), 32'd0);
      chk("rst_rdata", instr_rdata_id_o, 32'd0);
      chk("rst_err", 32'(instr_fetch_err_o), 32'd0);
      chk("rst_pc_id", pc_id_o, 32'd0);

      // Boot: first request right after release, IF/ID valid two cycles after the grant.
      rst = 1'b0;
      #1;
      chk("boot_req", 32'(instr_req_o), 32'd1);
      chk("boot_addr0", instr_addr_o, 32'h80);
      tick();
      chk("boot_addr1", instr_addr_o, 32'h84);
      chk("boot_valid_early", 32'(instr_valid_id_o), 32'd0);
      tick();
      chk("boot_valid", 32'(instr_valid_id_o), 32'd1);
      chk("boot_pc_id", pc_id_o, 32'h80);
      chk("boot_rdata", instr_rdata_id_o, mem_data(32'h80));
      for (int j = 1; j <= 5; j++) begin
         tick();
         chk("stream_valid", 32'(instr_valid_id_o), 32'd1);
         chk("stream_pc_id", pc_id_o, 32'h80 + 32'(4 * j));
      end

      // Backpressure: IF/ID holds 0x94, FIFO fills with 0x98/0x9C, fetching stops at 0xA0.
      id_in_ready_i = 1'b0;
      repeat (6) tick();
      chk("stall_pc_id", pc_id_o, 32'h94);
      chk("stall_valid", 32'(instr_valid_id_o), 32'd1);
      chk("stall_pc_if", pc_if_o, 32'hA0);
      chk("stall_req", 32'(instr_req_o), 32'd0);
      id_in_ready_i = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         tick();
         chk("release_valid", 32'(instr_valid_id_o), 32'd1);
         chk("release_pc_id", pc_id_o, 32'h94 + 32'(4 * j));
      end

      // Redirect target table, each applied on a running stream.
      for (int i = 0; i < 6; i++) begin
         redirect(vecs[i].mux, vecs[i].exc, vecs[i].br, vecs[i].mtvec);
         chk($sformatf("vec%0d_addr", i), instr_addr_o, vecs[i].exp);
         chk($sformatf("vec%0d_req", i), 32'(instr_req_o), 32'd1);
         chk($sformatf("vec%0d_flush", i), 32'(instr_valid_id_o), 32'd0);
         tick();
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(instr_valid_id_o), 32'd1);
         chk($sformatf("vec%0d_pc_id", i), pc_id_o, vecs[i].exp);
         chk($sformatf("vec%0d_rdata", i), instr_rdata_id_o, mem_data(vecs[i].exp));
      end

      // Jump flush with two responses outstanding.
      mem_hold = 1'b1;
      repeat (4) tick();
      chk("hold_req", 32'(instr_req_o), 32'd0);
      chk("hold_valid", 32'(instr_valid_id_o), 32'd0);
      mem_hold = 1'b0;
      tick();
      redirect(2'b01, 1'b0, 32'h200, 32'h0);
      chk("jump_addr", instr_addr_o, 32'h200);
      chk("jump_req", 32'(instr_req_o), 32'd1);
      tick();
      chk("jump_discard", 32'(instr_valid_id_o), 32'd0);
      tick();
      chk("jump_valid", 32'(instr_valid_id_o), 32'd1);
      chk("jump_pc_id", pc_id_o, 32'h200);
      chk("jump_rdata", instr_rdata_id_o, mem_data(32'h200));
      tick();
      chk("jump_next_pc", pc_id_o, 32'h204);

      // Fetch error on 0x84 halts fetching until the next redirect.
      err_addr = 32'h84;
      redirect(2'b00, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      chk("err_pc0", pc_id_o, 32'h80);
      chk("err_flag0", 32'(instr_fetch_err_o), 32'd0);
      tick();
      chk("err_pc_id", pc_id_o, 32'h84);
      chk("err_flag", 32'(instr_fetch_err_o), 32'd1);
      chk("err_valid", 32'(instr_valid_id_o), 32'd1);
      chk("err_req", 32'(instr_req_o), 32'd0);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("halt_req", 32'(instr_req_o), 32'd0);
      end
      chk("halt_valid", 32'(instr_valid_id_o), 32'd0);
      chk("halt_pc_if", pc_if_o, 32'h8C);
      err_addr = 32'hFFFF_FFFF;

      // Kill beats a load with the FIFO holding 0x304/0x308.
      redirect(2'b01, 1'b0, 32'h300, 32'h0);
      tick();
      tick();
      chk("kill_base_pc", pc_id_o, 32'h300);
      id_in_ready_i = 1'b0;
      repeat (3) tick();
      chk("kill_fill_pc_if", pc_if_o, 32'h30C);
      chk("kill_fill_req", 32'(instr_req_o), 32'd0);
      instr_valid_clear_i = 1'b1;
      id_in_ready_i = 1'b1;
      tick();
      instr_valid_clear_i = 1'b0;
      chk("kill_valid", 32'(instr_valid_id_o), 32'd0);
      tick();
      chk("kill_head_valid", 32'(instr_valid_id_o), 32'd1);
      chk("kill_head_pc", pc_id_o, 32'h304);
      tick();
      chk("kill_next_pc", pc_id_o, 32'h308);
      tick();
      chk("kill_next2_pc", pc_id_o, 32'h30C);

      // Asynchronous reset in the middle of a stream.
      tick();
      rst = 1'b1;
      #1;
      chk("mrst_valid", 32'(instr_valid_id_o), 32'd0);
      chk("mrst_addr", instr_addr_o, 32'h80);
      chk("mrst_req", 32'(instr_req_o), 32'd0);
      chk("mrst_pc_id", pc_id_o, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
